// File: rtl/alu_issue_ctrl.sv
// Issue controller between decode and the combinational ALU: registers operands,
// waits the op latency, then hands the result to writeback. Optional macro ALU_FLAGS_EN adds out_flags.
module alu_issue_ctrl #(
  parameter int MUL_LAT  = 2,
  parameter int EXEC_LAT = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [5:0]  in_op,
  input  logic [31:0] in_ra,
  input  logic [31:0] in_rb,
  input  logic [15:0] in_lit,
  input  logic [4:0]  in_rc,
  output logic [5:0]  alu_fn,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  input  logic [31:0] alu_res,
  input  logic        alu_z,
  input  logic        alu_v,
  input  logic        alu_n,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic [4:0]  out_rc,
  output logic        out_illegal
`ifdef ALU_FLAGS_EN
  ,
  output logic [2:0]  out_flags
`endif
);

  localparam int MAX_LAT = (MUL_LAT > EXEC_LAT) ? MUL_LAT : EXEC_LAT;
  localparam int CW      = $clog2(MAX_LAT + 1);

  typedef enum logic [1:0] {IDLE, EXEC, HOLD} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt;
  logic [CW-1:0] lat;
  logic          accept;
  logic          legal;
  logic [5:0]    dec_fn;
  logic [31:0]   opb;

  // Opcode decode; bit 5 must be set for any legal op, bit 4 selects the literal.
  always_comb begin
    dec_fn = 6'h1A;
    legal  = in_op[5];
    case (in_op[3:0])
      4'h0: dec_fn = 6'h00;
      4'h1: dec_fn = 6'h01;
      4'h2: dec_fn = 6'h02;
      4'h4: dec_fn = 6'h33;
      4'h5: dec_fn = 6'h35;
      4'h6: dec_fn = 6'h37;
      4'h8: dec_fn = 6'h18;
      4'h9: dec_fn = 6'h1E;
      4'hA: dec_fn = 6'h16;
      4'hC: dec_fn = 6'h20;
      4'hD: dec_fn = 6'h21;
      4'hE: dec_fn = 6'h23;
      default: legal = 1'b0;
    endcase
    opb = in_op[4] ? {{16{in_lit[15]}}, in_lit} : in_rb;
    lat = (in_op[3:0] == 4'h2) ? CW'(MUL_LAT) : CW'(EXEC_LAT);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // HOLD releases its slot and may take the next op in the same cycle.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = legal ? EXEC : HOLD;
      end
      EXEC: begin
        if (cnt == '0) state_nxt = HOLD;
      end
      HOLD: begin
        out_valid = 1'b1;
        in_ready  = out_ready;
        if (out_ready) state_nxt = in_valid ? (legal ? EXEC : HOLD) : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    accept = in_valid & in_ready;
  end

  // The counter reaches zero after L edges, so capture lands one edge later (t+L+1).
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      alu_fn      <= 6'h1A;
      alu_a       <= '0;
      alu_b       <= '0;
      out_data    <= '0;
      out_rc      <= '0;
      out_illegal <= 1'b0;
      cnt         <= '0;
`ifdef ALU_FLAGS_EN
      out_flags   <= 3'b000;
`endif
    end else if (accept) begin
      out_rc <= in_rc;
      if (legal) begin
        alu_fn <= dec_fn;
        alu_a  <= in_ra;
        alu_b  <= opb;
        cnt    <= lat;
      end else begin
        out_data    <= '0;
        out_illegal <= 1'b1;
`ifdef ALU_FLAGS_EN
        out_flags   <= 3'b000;
`endif
      end
    end else if (state == EXEC) begin
      if (cnt == '0) begin
        out_data    <= alu_res;
        out_illegal <= 1'b0;
`ifdef ALU_FLAGS_EN
        out_flags   <= {alu_z, alu_v, alu_n};
`endif
      end else begin
        cnt <= cnt - 1'b1;
      end
    end
  end

`ifndef ALU_FLAGS_EN
  logic unused_flags;
  assign unused_flags = alu_z ^ alu_v ^ alu_n;
`endif

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl with a behavioural ALU closing the loop.
module tb_alu_issue_ctrl;

  logic        clk;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic [5:0]  in_op;
  logic [31:0] in_ra;
  logic [31:0] in_rb;
  logic [15:0] in_lit;
  logic [4:0]  in_rc;
  logic [5:0]  alu_fn;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [31:0] alu_res;
  logic        alu_z;
  logic        alu_v;
  logic        alu_n;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [4:0]  out_rc;
  logic        out_illegal;
`ifdef ALU_FLAGS_EN
  logic [2:0]  out_flags;
`endif

  int total = 0;
  int bad   = 0;

  alu_issue_ctrl #(.MUL_LAT(2), .EXEC_LAT(1)) dut (
    .clk(clk), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_ra(in_ra), .in_rb(in_rb), .in_lit(in_lit), .in_rc(in_rc),
    .alu_fn(alu_fn), .alu_a(alu_a), .alu_b(alu_b),
    .alu_res(alu_res), .alu_z(alu_z), .alu_v(alu_v), .alu_n(alu_n),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_rc(out_rc), .out_illegal(out_illegal)
`ifdef ALU_FLAGS_EN
    , .out_flags(out_flags)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Behavioural combinational ALU driven by the DUT's registered outputs.
  always_comb begin
    alu_res = alu_a;
    case (alu_fn)
      6'h00: alu_res = alu_a + alu_b;
      6'h01: alu_res = alu_a - alu_b;
      6'h02: alu_res = alu_a * alu_b;
      6'h33: alu_res = {31'd0, alu_a == alu_b};
      6'h35: alu_res = {31'd0, $signed(alu_a) < $signed(alu_b)};
      6'h37: alu_res = {31'd0, $signed(alu_a) <= $signed(alu_b)};
      6'h18: alu_res = alu_a & alu_b;
      6'h1E: alu_res = alu_a | alu_b;
      6'h16: alu_res = alu_a ^ alu_b;
      6'h20: alu_res = alu_a << alu_b[4:0];
      6'h21: alu_res = alu_a >> alu_b[4:0];
      6'h23: alu_res = $unsigned($signed(alu_a) >>> alu_b[4:0]);
      default: alu_res = alu_a;
    endcase
    alu_z = (alu_res == 32'd0);
    alu_v = 1'b0;
    alu_n = alu_res[31];
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("[TB] FAIL %s got=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic setInstr(input logic [5:0] op, input logic [31:0] ra, input logic [31:0] rb,
                          input logic [15:0] lit, input logic [4:0] rc);
    in_op    = op;
    in_ra    = ra;
    in_rb    = rb;
    in_lit   = lit;
    in_rc    = rc;
    in_valid = 1'b1;
  endtask

  // Offer one instruction from IDLE; returns 1ns after the accepting edge.
  task automatic applyStimulus(input logic [5:0] op, input logic [31:0] ra, input logic [31:0] rb,
                               input logic [15:0] lit, input logic [4:0] rc);
    setInstr(op, ra, rb, lit, rc);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic releaseResult();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  initial begin
    reset_n   = 1'b0;
    in_valid  = 1'b0;
    in_op     = '0;
    in_ra     = '0;
    in_rb     = '0;
    in_lit    = '0;
    in_rc     = '0;
    out_ready = 1'b0;
    #12;
    checkOutput("rst_in_ready", 32'(in_ready), 32'd1);
    checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_alu_fn", 32'(alu_fn), 32'h1A);
    checkOutput("rst_out_data", out_data, 32'd0);
    checkOutput("rst_illegal", 32'(out_illegal), 32'd0);
`ifdef ALU_FLAGS_EN
    checkOutput("rst_flags", 32'(out_flags), 32'd0);
`endif
    reset_n = 1'b1;
    tick();

    // ADD register form, EXEC_LAT=1
    applyStimulus(6'h20, 32'd5, 32'd7, 16'h0, 5'd3);
    checkOutput("add_fn", 32'(alu_fn), 32'h00);
    checkOutput("add_b", alu_b, 32'd7);
    checkOutput("add_busy", 32'(in_ready), 32'd0);
    checkOutput("add_v1", 32'(out_valid), 32'd0);
    tick();
    checkOutput("add_v2", 32'(out_valid), 32'd0);
    tick();
    checkOutput("add_valid", 32'(out_valid), 32'd1);
    checkOutput("add_data", out_data, 32'd12);
    checkOutput("add_rc", 32'(out_rc), 32'd3);
    releaseResult();
    checkOutput("add_idle", 32'(out_valid), 32'd0);

    // SUBC with an all-ones literal
    applyStimulus(6'h31, 32'd3, 32'd99, 16'hFFFF, 5'd1);
    checkOutput("subc_fn", 32'(alu_fn), 32'h01);
    checkOutput("subc_b", alu_b, 32'hFFFF_FFFF);
    tick();
    tick();
    checkOutput("subc_data", out_data, 32'd4);
`ifdef ALU_FLAGS_EN
    checkOutput("subc_flags", 32'(out_flags), 32'd0);
`endif
    releaseResult();

    // MUL, MUL_LAT=2
    applyStimulus(6'h22, 32'd6, 32'd7, 16'h0, 5'd2);
    checkOutput("mul_v1", 32'(out_valid), 32'd0);
    tick();
    checkOutput("mul_v2", 32'(out_valid), 32'd0);
    tick();
    checkOutput("mul_v3", 32'(out_valid), 32'd0);
    tick();
    checkOutput("mul_valid", 32'(out_valid), 32'd1);
    checkOutput("mul_data", out_data, 32'd42);
    releaseResult();

    // SRA with a positive literal shift amount
    applyStimulus(6'h3E, 32'h8000_0000, 32'd0, 16'h0004, 5'd7);
    checkOutput("sra_b", alu_b, 32'd4);
    tick();
    tick();
    checkOutput("sra_data", out_data, 32'hF800_0000);
    releaseResult();

    // CMPLT signed, then an illegal opcode
    applyStimulus(6'h25, 32'hFFFF_FFFF, 32'd1, 16'h0, 5'd8);
    tick();
    tick();
    checkOutput("cmplt_data", out_data, 32'd1);
    releaseResult();
    applyStimulus(6'h23, 32'd11, 32'd22, 16'h0, 5'd9);
    checkOutput("ill_valid", 32'(out_valid), 32'd1);
    checkOutput("ill_flag", 32'(out_illegal), 32'd1);
    checkOutput("ill_data", out_data, 32'd0);
    checkOutput("ill_rc", 32'(out_rc), 32'd9);
    checkOutput("ill_fn_kept", 32'(alu_fn), 32'h35);
    checkOutput("ill_a_kept", alu_a, 32'hFFFF_FFFF);
    releaseResult();

    // XOR result stalled by writeback while the next op waits
    applyStimulus(6'h2A, 32'h0000_F0F0, 32'h0000_0FF0, 16'h0, 5'd4);
    tick();
    tick();
    checkOutput("xor_data", out_data, 32'h0000_FF00);
    setInstr(6'h29, 32'h0000_00F0, 32'h0000_000F, 16'h0, 5'd5);
    for (int i = 0; i < 5; i++) begin
      checkOutput("stall_ready", 32'(in_ready), 32'd0);
      checkOutput("stall_data", out_data, 32'h0000_FF00);
      checkOutput("stall_rc", 32'(out_rc), 32'd4);
      checkOutput("stall_fn", 32'(alu_fn), 32'h16);
      tick();
    end
    out_ready = 1'b1;
    #1;
    checkOutput("handoff_ready", 32'(in_ready), 32'd1);
    tick();
    out_ready = 1'b0;
    in_valid  = 1'b0;
    checkOutput("or_fn", 32'(alu_fn), 32'h1E);
    checkOutput("or_v1", 32'(out_valid), 32'd0);
    tick();
    tick();
    checkOutput("or_valid", 32'(out_valid), 32'd1);
    checkOutput("or_data", out_data, 32'h0000_00FF);
    checkOutput("or_rc", 32'(out_rc), 32'd5);
    releaseResult();

    // Reset asserted mid MUL execution
    applyStimulus(6'h22, 32'd3, 32'd3, 16'h0, 5'd6);
    tick();
    reset_n = 1'b0;
    #1;
    checkOutput("abort_valid", 32'(out_valid), 32'd0);
    checkOutput("abort_ready", 32'(in_ready), 32'd1);
    checkOutput("abort_fn", 32'(alu_fn), 32'h1A);
    tick();
    reset_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      checkOutput("abort_no_stale", 32'(out_valid), 32'd0);
    end
    checkOutput("abort_data", out_data, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
